// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: shares one memory port between PTW, dmem and fetch requesters.
// One transaction is outstanding at a time. Arbitration happens only in S_IDLE, with priority
// ptw > dmem > fetch. The winner's command is held on mem_* for the whole of S_BUSY. Read data
// is registered and returned with a one-cycle *_valid pulse in S_RESP.
//
// Optional feature, enabled by defining MEM_SCHED_STARVE_GUARD_EN:
//   A saturating counter tracks how often fetch loses arbitration. Once it reaches
//   STARVE_LIMIT, fetch is given priority over dmem. PTW always keeps the highest priority.
//
// Ports:
//   clk, reset (async, active-low)
//   ptw_req/ptw_addr, dmem_req/dmem_cmd/dmem_addr/dmem_wdata/dmem_mask, fetch_req/fetch_addr
//   ptw_valid/dmem_valid/fetch_valid, resp_data, busy
//   mem_enable/mem_cmd/mem_addr/mem_wdata/mem_mask (to memory), mem_data/mem_valid (from memory)

`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module mem_port_scheduler #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ptw_req,
  input  logic [ADDR_W-1:0]   ptw_addr,
  input  logic                dmem_req,
  input  logic                dmem_cmd,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_mask,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                ptw_valid,
  output logic                dmem_valid,
  output logic                fetch_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy,
  output logic                mem_enable,
  output logic                mem_cmd,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                mem_valid
);

  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_PTW   = 2'd1;
  localparam logic [1:0] OWN_DMEM  = 2'd2;
  localparam logic [1:0] OWN_FETCH = 2'd3;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic       any_req;
  logic       fetch_first;
  logic [1:0] grant_id;

  assign any_req = ptw_req | dmem_req | fetch_req;

`ifdef MEM_SCHED_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;

  assign fetch_first = (starve_q == StarveMax);

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE && any_req) begin
      if (grant_id == OWN_FETCH) begin
        starve_d = '0;
      end else if (fetch_req && starve_q != StarveMax) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Fixed priority. A starving fetch may jump ahead of dmem, but never ahead of PTW.
  always_comb begin
    grant_id = OWN_NONE;
    if (ptw_req) begin
      grant_id = OWN_PTW;
    end else if (fetch_first && fetch_req) begin
      grant_id = OWN_FETCH;
    end else if (dmem_req) begin
      grant_id = OWN_DMEM;
    end else if (fetch_req) begin
      grant_id = OWN_FETCH;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_BUSY;
          owner_d = grant_id;
          case (grant_id)
            OWN_PTW: begin
              cmd_d   = `MEM_CMD_READ;
              addr_d  = ptw_addr;
              wdata_d = '0;
              mask_d  = '0;
            end
            OWN_DMEM: begin
              cmd_d   = dmem_cmd;
              addr_d  = dmem_addr;
              wdata_d = dmem_wdata;
              mask_d  = dmem_mask;
            end
            OWN_FETCH: begin
              cmd_d   = `MEM_CMD_READ;
              addr_d  = fetch_addr;
              wdata_d = '0;
              mask_d  = '0;
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // Write completions capture mem_data too; the value is simply unused.
        if (mem_valid) begin
          state_d = S_RESP;
          resp_d  = mem_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      cmd_q   <= `MEM_CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      resp_q  <= resp_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign mem_enable  = (state_q == S_BUSY);
  assign ptw_valid   = (state_q == S_RESP) && (owner_q == OWN_PTW);
  assign dmem_valid  = (state_q == S_RESP) && (owner_q == OWN_DMEM);
  assign fetch_valid = (state_q == S_RESP) && (owner_q == OWN_FETCH);
  assign resp_data   = resp_q;
  assign mem_cmd     = cmd_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_mask    = mask_q;

endmodule
